// File: rtl/spi2adc_if.sv
// ============================================================================
//  spi2adc_if : host-side control/result signals plus the ADC SPI pins
//  Revision   : 1.0
// ============================================================================
`default_nettype none

interface spi2adc_if;
  logic       start;
  logic       channel;
  logic       adc_sdo;
  logic       adc_cs;
  logic       adc_sck;
  logic       adc_sdi;
  logic [9:0] data_out;
  logic       data_valid;
  logic       busy;

  // The converter is the SPI master; the slave view is the ADC plus host.
  modport master (
    input  start, channel, adc_sdo,
    output adc_cs, adc_sck, adc_sdi, data_out, data_valid, busy
  );

  modport slave (
    output start, channel, adc_sdo,
    input  adc_cs, adc_sck, adc_sdi, data_out, data_valid, busy
  );
endinterface

`default_nettype wire

// File: rtl/spi2adc.sv
// ============================================================================
//  spi2adc  : SPI master running one 16-clock single-ended conversion frame
//             on a 10-bit ADC per accepted start request
//  Revision : 1.0
// ============================================================================
`default_nettype none

module spi2adc #(
  parameter int SCK_HALF = 25
) (
  input  wire logic  sysclk,
  input  wire logic  rst_n,
  spi2adc_if.master  bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_SHIFT = 3'd2,
    S_HOLD  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [7:0] C_HALF_LOAD = 8'(SCK_HALF - 1);
  localparam logic [4:0] C_LAST_BIT  = 5'd15;
  localparam logic [4:0] C_KEEP_LO   = 5'd5;
  localparam logic [4:0] C_KEEP_HI   = 5'd14;

  state_t     r_state;
  state_t     w_next;
  logic [7:0] r_half_cnt;
  logic [4:0] r_bit_cnt;
  logic       r_sck_hi;
  logic       r_channel;
  logic [9:0] r_shift;
  logic [9:0] r_data_out;

  logic       w_half_done;
  logic       w_sample;
  logic       w_cmd_bit;
  logic       w_cs;
  logic       w_sck;
  logic       w_sdi;
  logic       w_valid;
  logic       w_busy;

  assign w_half_done = (r_half_cnt == 8'd0);

  // First sysclk of each high phase: r_bit_cnt holds (edge number - 1).
  assign w_sample = (r_state == S_SHIFT) && r_sck_hi && (r_half_cnt == C_HALF_LOAD)
                    && (r_bit_cnt >= C_KEEP_LO) && (r_bit_cnt <= C_KEEP_HI);

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (bus.start) w_next = S_SETUP;
      S_SETUP: if (w_half_done) w_next = S_SHIFT;
      S_SHIFT: if (w_half_done && r_sck_hi && (r_bit_cnt == C_LAST_BIT)) w_next = S_HOLD;
      S_HOLD:  if (w_half_done) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Command word, MSB first: start, single-ended, channel, MSB-first.
  always_comb begin
    w_cmd_bit = 1'b0;
    case (r_bit_cnt)
      5'd0, 5'd1, 5'd3: w_cmd_bit = 1'b1;
      5'd2:             w_cmd_bit = r_channel;
      default:          w_cmd_bit = 1'b0;
    endcase
  end

  always_comb begin
    w_cs    = 1'b1;
    w_sck   = 1'b0;
    w_sdi   = 1'b0;
    w_valid = 1'b0;
    w_busy  = 1'b1;
    unique case (r_state)
      S_IDLE:  w_busy = 1'b0;
      S_SETUP: begin
        w_cs  = 1'b0;
        w_sdi = w_cmd_bit;
      end
      S_SHIFT: begin
        w_cs  = 1'b0;
        w_sck = r_sck_hi;
        w_sdi = w_cmd_bit;
      end
      S_HOLD:  w_cs = 1'b0;
      S_DONE:  w_valid = 1'b1;
      default: w_busy = 1'b0;
    endcase
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      r_half_cnt <= 8'd0;
      r_bit_cnt  <= 5'd0;
      r_sck_hi   <= 1'b0;
      r_channel  <= 1'b0;
      r_shift    <= 10'd0;
      r_data_out <= 10'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_half_cnt <= C_HALF_LOAD;
          r_bit_cnt  <= 5'd0;
          r_sck_hi   <= 1'b0;
          if (bus.start) r_channel <= bus.channel;
        end
        S_SETUP, S_HOLD: begin
          r_half_cnt <= w_half_done ? C_HALF_LOAD : r_half_cnt - 8'd1;
        end
        S_SHIFT: begin
          if (w_half_done) begin
            r_half_cnt <= C_HALF_LOAD;
            r_sck_hi   <= ~r_sck_hi;
            if (r_sck_hi) r_bit_cnt <= r_bit_cnt + 5'd1;
          end else begin
            r_half_cnt <= r_half_cnt - 8'd1;
          end
          if (w_sample) r_shift <= {r_shift[8:0], bus.adc_sdo};
        end
        default: ;
      endcase
      // Loaded on entry to DONE so the result is visible with data_valid.
      if ((r_state == S_HOLD) && w_half_done) r_data_out <= r_shift;
    end
  end

  assign bus.adc_cs     = w_cs;
  assign bus.adc_sck    = w_sck;
  assign bus.adc_sdi    = w_sdi;
  assign bus.data_out   = r_data_out;
  assign bus.data_valid = w_valid;
  assign bus.busy       = w_busy;

endmodule

`default_nettype wire

// File: tb/tb_spi2adc.sv
// ============================================================================
//  tb_spi2adc : scoreboard bench for spi2adc with a behavioural ADC model
//  Revision   : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_spi2adc;

  localparam int SCK_HALF = 4;
  localparam int CS_LOW   = 34 * SCK_HALF;

  logic sysclk = 1'b0;
  logic rst_n  = 1'b0;

  spi2adc_if bus();

  spi2adc #(.SCK_HALF(SCK_HALF)) dut (
    .sysclk (sysclk),
    .rst_n  (rst_n),
    .bus    (bus)
  );

  always #5 sysclk = ~sysclk;

  typedef struct {
    logic [9:0] data;
    logic       ch;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ADC model: next data bit launched on each SCK falling edge.
  logic [9:0] model_val = 10'h000;
  int         fall_cnt  = 0;

  always @(negedge bus.adc_sck or posedge bus.adc_cs) begin
    if (bus.adc_cs) begin
      fall_cnt    = 0;
      bus.adc_sdo = 1'b0;
    end else begin
      fall_cnt++;
      if (fall_cnt >= 5 && fall_cnt <= 14) bus.adc_sdo = model_val[14 - fall_cnt];
      else                                 bus.adc_sdo = 1'b0;
    end
  end

  int         cyc         = 0;
  int         cs_low      = 0;
  int         rise_cnt    = 0;
  int         dv_count    = 0;
  int         last_dv_cyc = 0;
  logic       prev_sck    = 1'b0;
  logic       prev_cs     = 1'b1;
  logic       last_sdi_lo = 1'b0;
  logic       tail_bad    = 1'b0;
  logic       gap_mode    = 1'b0;
  logic       dv_pending  = 1'b0;
  logic [3:0] cmd_seen    = 4'h0;
  exp_t       e;

  always @(negedge sysclk) begin
    cyc++;
    if (!rst_n) begin
      cs_low     = 0;
      rise_cnt   = 0;
      cmd_seen   = 4'h0;
      tail_bad   = 1'b0;
      dv_pending = 1'b0;
    end else begin
      if (!bus.adc_cs) cs_low++;
      if (bus.adc_sck && !prev_sck) begin
        rise_cnt++;
        if (rise_cnt <= 4)    cmd_seen[rise_cnt - 1] = last_sdi_lo;
        else if (last_sdi_lo) tail_bad = 1'b1;
      end
      if (!bus.adc_sck) last_sdi_lo = bus.adc_sdi;
      if (!bus.adc_cs && prev_cs && dv_pending && gap_mode) begin
        chk("done_to_cs_fall_gap", 32'(cyc - last_dv_cyc), 32'd2);
        dv_pending = 1'b0;
      end
      if (bus.data_valid) begin
        dv_count++;
        last_dv_cyc = cyc;
        dv_pending  = gap_mode;
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_data_valid: got data_out=0x%0h expected no pulse", bus.data_out);
        end else begin
          e = sb.pop_front();
          chk("data_out",      32'(bus.data_out), 32'(e.data));
          chk("cs_low_cycles", 32'(cs_low), 32'(CS_LOW));
          chk("sck_rises",     32'(rise_cnt), 32'd16);
          chk("cmd_bits",      32'(cmd_seen), 32'({1'b1, e.ch, 1'b1, 1'b1}));
          chk("sdi_tail_zero", 32'(tail_bad), 32'd0);
          chk("busy_in_done",  32'(bus.busy), 32'd1);
          chk("cs_high_done",  32'(bus.adc_cs), 32'd1);
        end
        cs_low   = 0;
        rise_cnt = 0;
        cmd_seen = 4'h0;
        tail_bad = 1'b0;
      end
    end
    prev_sck = bus.adc_sck;
    prev_cs  = bus.adc_cs;
  end

  task automatic wait_dv(input int target, input int budget, input bit toggle);
    int n = 0;
    while (dv_count < target && n < budget) begin
      @(posedge sysclk);
      #1;
      if (toggle) bus.channel = ~bus.channel;
      n++;
    end
    if (dv_count < target) begin
      n_checks++;
      n_fail++;
      $display("FAIL dv_timeout: got %0d pulses expected %0d", dv_count, target);
    end
  endtask

  task automatic do_frame(input logic ch, input logic [9:0] val, input bit toggle);
    int target;
    target = dv_count + 1;
    sb.push_back('{data: val, ch: ch});
    model_val = val;
    @(posedge sysclk); #1;
    bus.channel = ch;
    bus.start   = 1'b1;
    @(posedge sysclk); #1;
    bus.start   = 1'b0;
    wait_dv(target, 400, toggle);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_cs"},         32'(bus.adc_cs), 32'd1);
    chk({tag, "_sck"},        32'(bus.adc_sck), 32'd0);
    chk({tag, "_sdi"},        32'(bus.adc_sdi), 32'd0);
    chk({tag, "_data_out"},   32'(bus.data_out), 32'h000);
    chk({tag, "_data_valid"}, 32'(bus.data_valid), 32'd0);
    chk({tag, "_busy"},       32'(bus.busy), 32'd0);
  endtask

  initial begin
    int base;
    int n;
    bus.start   = 1'b0;
    bus.channel = 1'b0;
    repeat (3) @(posedge sysclk);
    #2 rst_n = 1'b1;
    repeat (3) @(posedge sysclk);

    // Reset asserted mid-cycle while a frame is in flight.
    #1 bus.start = 1'b1;
    @(posedge sysclk); #1 bus.start = 1'b0;
    repeat (10) @(posedge sysclk);
    #1 chk("busy_before_reset", 32'(bus.busy), 32'd1);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("async_reset");
    repeat (2) @(posedge sysclk);
    #2 rst_n = 1'b1;
    repeat (3) @(posedge sysclk);

    do_frame(1'b0, 10'h2A5, 1'b0);
    repeat (20) @(posedge sysclk);
    #1 chk("data_out_hold", 32'(bus.data_out), 32'h2A5);

    do_frame(1'b1, 10'h3FF, 1'b0);
    do_frame(1'b0, 10'h000, 1'b0);

    // Start held high: back-to-back frames, no extras while busy.
    repeat (5) @(posedge sysclk);
    #1;
    base      = dv_count;
    gap_mode  = 1'b1;
    model_val = 10'h200;
    repeat (3) sb.push_back('{data: 10'h200, ch: 1'b0});
    bus.channel = 1'b0;
    bus.start   = 1'b1;
    wait_dv(base + 2, 800, 1'b0);
    n = 0;
    while (bus.adc_cs && n < 10) begin
      @(posedge sysclk); #1;
      n++;
    end
    chk("third_frame_started", 32'(bus.adc_cs), 32'd0);
    bus.start = 1'b0;
    wait_dv(base + 3, 400, 1'b0);
    gap_mode = 1'b0;
    repeat (300) @(posedge sysclk);
    #1;
    chk("no_extra_frames", 32'(dv_count), 32'(base + 3));
    chk("idle_after_hold", 32'(bus.busy), 32'd0);

    // Abort at SCK edge 8, then a clean frame.
    model_val = 10'h155;
    @(posedge sysclk); #1;
    bus.channel = 1'b0;
    bus.start   = 1'b1;
    @(posedge sysclk); #1;
    bus.start   = 1'b0;
    n = 0;
    while (rise_cnt < 8 && n < 300) begin
      @(posedge sysclk);
      n++;
    end
    chk("reached_edge8", 32'(rise_cnt), 32'd8);
    base = dv_count;
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("abort");
    #20 rst_n = 1'b1;
    repeat (200) @(posedge sysclk);
    #1 chk("abort_no_valid", 32'(dv_count), 32'(base));
    do_frame(1'b0, 10'h155, 1'b0);

    // Channel toggles every cycle after acceptance; latched value must win.
    do_frame(1'b1, 10'h1C3, 1'b1);
    bus.channel = 1'b0;
    repeat (10) @(posedge sysclk);

    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
